// File: rtl/data_memory_responder.sv
// data_memory_responder
// Word-addressed data memory sitting behind the MEM stage's load/store port.
// One request is taken at a time over valid/ready. The response comes back a
// fixed LATENCY cycles after the accept edge and is held until it is taken.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | ready for a request; the accept edge does the write or captures the read
// S_WAIT | latency countdown; new requests are ignored
// S_RESP | response presented; held until a rsp_ready edge
//
// Memory contents have no reset. They power up as memory[i] = i. A store that
// has been accepted stays written even if reset arrives before its response.
module data_memory_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [3:0]  i_req_be,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [DEPTH-1:0][31:0] mem_init();
    logic [DEPTH-1:0][31:0] m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = 32'(i);
    end
    return m;
  endfunction

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_rsp_valid;
  logic [31:0]            r_rsp_rdata;
  logic                   r_rsp_err;
  logic [DEPTH-1:0][31:0] r_mem = mem_init();

  logic          w_req_ready;
  logic          w_accept;
  logic          w_in_range;
  logic [AW-1:0] w_idx;

  // Ready is gated by rst_n directly so that it drops the moment reset asserts.
  assign w_req_ready = (r_state == S_IDLE) && i_rst_n;
  assign w_accept    = i_req_valid && w_req_ready;
  // The compare uses all 32 address bits, so there is no aliasing onto low words.
  assign w_in_range  = (i_req_addr < 32'(DEPTH));
  assign w_idx       = i_req_addr[AW-1:0];

  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  // Byte-enabled store into the array on the accept edge. There is no reset here.
  always_ff @(posedge i_clk) begin
    if (w_accept && i_req_we && w_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (i_req_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= i_req_wdata[8*k +: 8];
        end
      end
    end
  end

  // Request/response sequencing. All response outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_err   <= !w_in_range;
            r_rsp_rdata <= (w_in_range && !i_req_we) ? r_mem[w_idx] : '0;
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder. Instance 0 has LATENCY=2 and instance 1 has
// LATENCY=1. The two instances share stimulus, but only the selected instance
// sees req_valid. A reference model is a plain array per instance.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready, sel;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;

  logic        v0, v1, rdy0, rdy1, rv0, rv1, er0, er1;
  logic [31:0] rd0, rd1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [2][32];

  always #5 clk = ~clk;

  assign v0        = req_valid & ~sel;
  assign v1        = req_valid & sel;
  assign req_ready = sel ? rdy1 : rdy0;
  assign rsp_valid = sel ? rv1 : rv0;
  assign rsp_rdata = sel ? rd1 : rd0;
  assign rsp_err   = sel ? er1 : er0;

  data_memory_responder #(.DEPTH(32), .LATENCY(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v0), .o_req_ready(rdy0),
    .i_req_we(req_we), .i_req_be(req_be), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rv0), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd0), .o_rsp_err(er0)
  );

  data_memory_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(rdy1),
    .i_req_we(req_we), .i_req_be(req_be), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rv1), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd1), .o_rsp_err(er1)
  );

  function automatic int lat_of(input logic s);
    return s ? 1 : 2;
  endfunction

  // Reference model: out-of-range gives an error with no data, a store merges
  // the enabled bytes and returns zero, and a load returns the current word.
  function automatic void mdl_op(input logic s, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] d, output logic e);
    int si;
    si = s ? 1 : 0;
    if (addr >= 32) begin
      d = 32'd0; e = 1'b1;
    end else if (we) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mdl[si][addr][8*k +: 8] = wdata[8*k +: 8];
      d = 32'd0; e = 1'b0;
    end else begin
      d = mdl[si][addr]; e = 1'b0;
    end
  endfunction

  // Runs one complete transaction with rsp_ready held at 1.
  task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                      output int lat, output logic rdy_after, output logic vld_after,
                      output logic tmo);
    int n;
    tmo = 1'b0; rd = '0; er = 1'b0; lat = 0; rdy_after = 1'b0; vld_after = 1'b1;
    @(negedge clk);
    req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin tmo = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin tmo = 1'b1; return; end
    rd = rsp_rdata; er = rsp_err;
    @(negedge clk);
    rdy_after = req_ready; vld_after = rsp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %0b want 0", req_ready); end
    checks++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_data: got %h/%0b want 0/0", rsp_rdata, rsp_err); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_load_basic();
    logic [31:0] rd, ed; logic er, ee, ra, va, tmo; int lat;
    mdl_op(1'b0, 1'b0, 4'h0, 32'd5, 32'd0, ed, ee);
    xact(1'b0, 4'h0, 32'd5, 32'd0, rd, er, lat, ra, va, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL load5_timeout: got timeout want response"); end
    checks++; if (rd !== 32'd5 || rd !== ed || er !== 1'b0) begin failures++; $display("FAIL load5_data: got %h/%0b want 00000005/0", rd, er); end
    checks++; if (lat != 2) begin failures++; $display("FAIL load5_latency: got %0d want 2", lat); end
    checks++; if (ra !== 1'b1 || va !== 1'b0) begin failures++; $display("FAIL load5_after: got ready=%0b valid=%0b want 1/0", ra, va); end
  endtask

  task automatic test_store_be();
    logic [31:0] rd, ed; logic er, ee, ra, va, tmo; int lat;
    mdl_op(1'b0, 1'b1, 4'b0101, 32'd3, 32'hAABBCCDD, ed, ee);
    xact(1'b1, 4'b0101, 32'd3, 32'hAABBCCDD, rd, er, lat, ra, va, tmo);
    checks++; if (tmo || rd !== 32'd0 || er !== 1'b0) begin failures++; $display("FAIL store3_rsp: got %h/%0b tmo=%0b want 0/0", rd, er, tmo); end
    mdl_op(1'b0, 1'b0, 4'h0, 32'd3, 32'd0, ed, ee);
    xact(1'b0, 4'h0, 32'd3, 32'd0, rd, er, lat, ra, va, tmo);
    checks++; if (tmo || rd !== 32'h00BB00DD || rd !== ed) begin failures++; $display("FAIL store3_readback: got %h want 00bb00dd", rd); end
    mdl_op(1'b0, 1'b1, 4'b0000, 32'd4, 32'hFFFFFFFF, ed, ee);
    xact(1'b1, 4'b0000, 32'd4, 32'hFFFFFFFF, rd, er, lat, ra, va, tmo);
    checks++; if (tmo || er !== 1'b0 || lat != 2) begin failures++; $display("FAIL store4_be0_rsp: got err=%0b lat=%0d tmo=%0b want 0/2/0", er, lat, tmo); end
    mdl_op(1'b0, 1'b0, 4'h0, 32'd4, 32'd0, ed, ee);
    xact(1'b0, 4'h0, 32'd4, 32'd0, rd, er, lat, ra, va, tmo);
    checks++; if (tmo || rd !== 32'd4 || rd !== ed) begin failures++; $display("FAIL store4_be0_readback: got %h want 00000004", rd); end
  endtask

  task automatic test_hold();
    logic [31:0] ed7, ed8; logic ee; int n;
    mdl_op(1'b0, 1'b0, 4'h0, 32'd7, 32'd0, ed7, ee);
    mdl_op(1'b0, 1'b0, 4'h0, 32'd8, 32'd0, ed8, ee);
    @(negedge clk);
    req_we = 1'b0; req_be = 4'h0; req_addr = 32'd7; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'd8;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== ed7 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold7_cycle%0d: got valid=%0b data=%h err=%0b ready=%0b want 1/%h/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, ed7);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL hold7_handshake: got valid=%0b ready=%0b want 0/1", rsp_valid, req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== ed8 || n != 2) begin failures++; $display("FAIL held_req8: got valid=%0b data=%h lat=%0d want 1/%h/2", rsp_valid, rsp_rdata, n, ed8); end
    @(negedge clk);
  endtask

  task automatic test_err();
    logic [31:0] rd, ed; logic er, ee, ra, va, tmo; int lat;
    logic [31:0] addrs [4];
    logic        wes   [4];
    addrs[0] = 32'd32;        wes[0] = 1'b1;
    addrs[1] = 32'd32;        wes[1] = 1'b0;
    addrs[2] = 32'hFFFFFFE0;  wes[2] = 1'b1;
    addrs[3] = 32'd0;         wes[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mdl_op(1'b0, wes[i], 4'hF, addrs[i], 32'h12345678, ed, ee);
      xact(wes[i], 4'hF, addrs[i], 32'h12345678, rd, er, lat, ra, va, tmo);
      checks++;
      if (tmo || rd !== ed || er !== ee) begin
        failures++;
        $display("FAIL err_addr_%h: got %h/%0b tmo=%0b want %h/%0b", addrs[i], rd, er, tmo, ed, ee);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic        we [N]; logic [3:0] be [N]; logic [31:0] ad [N]; logic [31:0] wd [N];
    logic [31:0] ed [N]; logic ee [N];
    int acc_c [N];
    int ir, ip; logic acc;
    for (int i = 0; i < N; i++) begin
      we[i] = (i == 2);
      be[i] = 4'(($urandom % 15) + 1);
      ad[i] = (i == 3) ? ad[2] : 32'($urandom_range(0, 31));
      wd[i] = $urandom;
      mdl_op(1'b1, we[i], be[i], ad[i], wd[i], ed[i], ee[i]);
      acc_c[i] = -100;
    end
    @(negedge clk);
    sel = 1'b1; rsp_ready = 1'b1;
    req_we = we[0]; req_be = be[0]; req_addr = ad[0]; req_wdata = wd[0]; req_valid = 1'b1;
    ir = 0; ip = 0;
    for (int c = 0; c < 80 && ip < N; c++) begin
      if (rsp_valid) begin
        checks++;
        if (rsp_rdata !== ed[ip] || rsp_err !== ee[ip]) begin
          failures++;
          $display("FAIL b2b_rsp%0d: got %h/%0b want %h/%0b", ip, rsp_rdata, rsp_err, ed[ip], ee[ip]);
        end
        ip++;
      end
      acc = req_valid && req_ready;
      if (acc && ir < N) acc_c[ir] = c;
      @(posedge clk);
      if (acc) begin
        ir++;
        #1;
        if (ir < N) begin
          req_we = we[ir]; req_be = be[ir]; req_addr = ad[ir]; req_wdata = wd[ir];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++; if (ip != N) begin failures++; $display("FAIL b2b_count: got %0d responses want %0d", ip, N); end
    for (int i = 1; i < N; i++) begin
      checks++;
      if (acc_c[i] - acc_c[i-1] != 2) begin
        failures++;
        $display("FAIL b2b_spacing%0d: got %0d cycles want 2", i, acc_c[i] - acc_c[i-1]);
      end
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ed, d; logic er, ee, ra, va, tmo; int lat, n;
    logic any_valid;
    d = $urandom;
    @(negedge clk);
    sel = 1'b0;
    req_we = 1'b1; req_be = 4'hF; req_addr = 32'd9; req_wdata = d; req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    mdl_op(1'b0, 1'b1, 4'hF, 32'd9, d, ed, ee);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got valid=%0b ready=%0b data=%h err=%0b want 0/0/0/0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (4) begin @(negedge clk); if (rsp_valid) any_valid = 1'b1; end
    checks++; if (any_valid) begin failures++; $display("FAIL midreset_dropped: got rsp_valid=1 want 0"); end
    mdl_op(1'b0, 1'b0, 4'h0, 32'd9, 32'd0, ed, ee);
    xact(1'b0, 4'h0, 32'd9, 32'd0, rd, er, lat, ra, va, tmo);
    checks++; if (tmo || rd !== ed || rd !== d) begin failures++; $display("FAIL midreset_commit: got %h want %h", rd, d); end
  endtask

  task automatic test_random();
    logic [31:0] rd, ed, ad, wd; logic er, ee, ra, va, tmo, we, s; logic [3:0] be; int lat;
    for (int i = 0; i < 60; i++) begin
      s  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      ad = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h20) : 32'($urandom_range(0, 33));
      wd = $urandom;
      @(negedge clk);
      sel = s;
      mdl_op(s, we, be, ad, wd, ed, ee);
      xact(we, be, ad, wd, rd, er, lat, ra, va, tmo);
      checks++;
      if (tmo || rd !== ed || er !== ee || lat != lat_of(s) || ra !== 1'b1 || va !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d sel=%0b we=%0b be=%h addr=%h: got %h/%0b lat=%0d rdy=%0b vld=%0b tmo=%0b want %h/%0b lat=%0d 1/0",
                 i, s, we, be, ad, rd, er, lat, ra, va, tmo, ed, ee, lat_of(s));
      end
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++)
        mdl[s][i] = 32'(i);
    test_reset();
    test_load_basic();
    test_store_be();
    test_hold();
    test_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
